// File: rtl/led_pwm_bank.sv
// led_pwm_bank
//   Multi-channel PWM LED brightness controller with a display scanner.
//   Each channel holds a host-written target duty (tgt). The live duty (cur)
//   either jumps to the target or fades toward it one step at a time. Live
//   duty only changes at PWM period boundaries, so a period is never cut short.
//   A scanner rotates a one-hot select across the channels and presents the
//   selected channel's live duty, for driving a multiplexed display.
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous reset, active low
//   wr_en    single-cycle write strobe
//   wr_ch    channel index for the write (out-of-range indices are ignored)
//   wr_duty  new target duty
//   fade_en  1: fade toward the target, 0: jump to the target
//   led      PWM outputs, active high
//   busy     per channel, 1 while live duty differs from the target
//   sel      one-hot scan select, active high
//   value    live duty of the selected channel
module led_pwm_bank #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 8,
    parameter int PRESC    = 4,
    parameter int FADE_PER = 1,
    parameter int SCAN_DIV = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(NUM_CH)-1:0] wr_ch,
    input  logic [WIDTH-1:0]          wr_duty,
    input  logic                      fade_en,
    output logic [NUM_CH-1:0]         led,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         sel,
    output logic [WIDTH-1:0]          value
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int PR_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int FD_W = (FADE_PER > 1) ? $clog2(FADE_PER) : 1;
    localparam int SC_W = $clog2(SCAN_DIV);

    localparam logic [PR_W-1:0]   PRESC_LAST = PR_W'(PRESC - 1);
    localparam logic [FD_W-1:0]   FADE_LAST  = FD_W'(FADE_PER - 1);
    localparam logic [SC_W-1:0]   SCAN_LAST  = SC_W'(SCAN_DIV - 1);
    localparam logic [CH_W-1:0]   IDX_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [WIDTH-1:0]  DUTY_MAX   = '1;

    logic [PR_W-1:0]  presc_reg;
    logic [WIDTH-1:0] pwm_cnt_reg;
    logic [FD_W-1:0]  fade_cnt_reg;
    logic [SC_W-1:0]  scan_cnt_reg;
    logic [CH_W-1:0]  idx_reg;
    logic [NUM_CH-1:0] sel_reg;
    logic [WIDTH-1:0]  value_reg;

    logic tick;
    logic boundary;
    logic fade_step;
    logic scan_wrap;

    // Live duty of every channel, gathered for the scan multiplexer.
    logic [NUM_CH-1:0][WIDTH-1:0] cur_all;

    assign tick      = (presc_reg == PRESC_LAST);
    assign boundary  = tick && (pwm_cnt_reg == DUTY_MAX);
    // Fade steps happen only on the boundary that wraps the shared fade counter.
    assign fade_step = boundary && fade_en && (fade_cnt_reg == FADE_LAST);
    assign scan_wrap = (scan_cnt_reg == SCAN_LAST);

    // Prescaler, PWM counter and shared fade counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_reg    <= '0;
            pwm_cnt_reg  <= '0;
            fade_cnt_reg <= '0;
        end else begin
            if (tick) begin
                presc_reg   <= '0;
                pwm_cnt_reg <= pwm_cnt_reg + WIDTH'(1);
            end else begin
                presc_reg <= presc_reg + PR_W'(1);
            end
            if (boundary && fade_en) begin
                if (fade_cnt_reg == FADE_LAST) begin
                    fade_cnt_reg <= '0;
                end else begin
                    fade_cnt_reg <= fade_cnt_reg + FD_W'(1);
                end
            end
        end
    end

    // Per-channel target, live duty, PWM output and busy flag.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] tgt_reg;
            logic [WIDTH-1:0] cur_reg;
            logic             led_reg;
            logic             busy_reg;
            logic             wr_hit;

            // An out-of-range wr_ch matches no channel, so the write is dropped.
            assign wr_hit = wr_en && (int'(wr_ch) == gi);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    tgt_reg  <= '0;
                    cur_reg  <= '0;
                    led_reg  <= 1'b0;
                    busy_reg <= 1'b0;
                end else begin
                    if (wr_hit) begin
                        tgt_reg <= wr_duty;
                    end
                    // The boundary reads tgt_reg before a same-edge write lands,
                    // so a write on the boundary cycle waits for the next one.
                    if (boundary) begin
                        if (!fade_en) begin
                            cur_reg <= tgt_reg;
                        end else if (fade_step) begin
                            if (cur_reg < tgt_reg) begin
                                cur_reg <= cur_reg + WIDTH'(1);
                            end else if (cur_reg > tgt_reg) begin
                                cur_reg <= cur_reg - WIDTH'(1);
                            end
                        end
                    end
                    // Full-scale duty is forced on; otherwise the compare would
                    // leave one low tick per period.
                    led_reg  <= (cur_reg == DUTY_MAX) ? 1'b1 : (pwm_cnt_reg < cur_reg);
                    busy_reg <= (cur_reg != tgt_reg);
                end
            end

            assign cur_all[gi] = cur_reg;
            assign led[gi]     = led_reg;
            assign busy[gi]    = busy_reg;
        end
    endgenerate

    // Display scanner: slot counter, channel index and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_reg <= '0;
            idx_reg      <= '0;
            sel_reg      <= NUM_CH'(1);
            value_reg    <= '0;
        end else begin
            if (scan_wrap) begin
                scan_cnt_reg <= '0;
                idx_reg      <= (idx_reg == IDX_LAST) ? '0 : idx_reg + CH_W'(1);
            end else begin
                scan_cnt_reg <= scan_cnt_reg + SC_W'(1);
            end
            sel_reg   <= NUM_CH'(1) << idx_reg;
            // Refreshed every cycle so cur changes show up within a slot.
            value_reg <= cur_all[idx_reg];
        end
    end

    assign sel   = sel_reg;
    assign value = value_reg;

endmodule

// File: tb/tb_led_pwm_bank.sv
// Testbench for led_pwm_bank (NUM_CH=4, WIDTH=4, PRESC=2, FADE_PER=1,
// SCAN_DIV=8). The reference model derives counter phases arithmetically
// from the number of clock edges since reset release.
module tb_led_pwm_bank;

    localparam int NUM_CH   = 4;
    localparam int WIDTH    = 4;
    localparam int PRESC    = 2;
    localparam int FADE_PER = 1;
    localparam int SCAN_DIV = 8;
    localparam int DMAX     = (1 << WIDTH) - 1;
    localparam int PERIOD   = (1 << WIDTH) * PRESC;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en = 1'b0;
    logic [1:0]        wr_ch = '0;
    logic [WIDTH-1:0]  wr_duty = '0;
    logic              fade_en = 1'b0;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] sel;
    logic [WIDTH-1:0]  value;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int c;               // clock edges since reset release
    int fcnt;            // boundaries counted toward the next fade step
    int tgt_m [NUM_CH];
    int cur_m [NUM_CH];

    led_pwm_bank #(
        .NUM_CH  (NUM_CH),
        .WIDTH   (WIDTH),
        .PRESC   (PRESC),
        .FADE_PER(FADE_PER),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_duty(wr_duty),
        .fade_en(fade_en),
        .led    (led),
        .busy   (busy),
        .sel    (sel),
        .value  (value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        c    = 0;
        fcnt = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            tgt_m[i] = 0;
            cur_m[i] = 0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_led"},   led,   0);
        chk({tag, "_busy"},  busy,  0);
        chk({tag, "_sel"},   sel,   1);
        chk({tag, "_value"}, value, 0);
    endtask

    // One clock edge: predict outputs from the pre-edge model state, advance
    // the model, then compare after the edge.
    task automatic step();
        int pwm;
        int idx;
        bit bnd;
        logic [NUM_CH-1:0] led_e;
        logic [NUM_CH-1:0] busy_e;
        int val_e;
        pwm = (c / PRESC) % (DMAX + 1);
        bnd = ((c % PERIOD) == PERIOD - 1);
        idx = (c / SCAN_DIV) % NUM_CH;
        for (int i = 0; i < NUM_CH; i++) begin
            led_e[i]  = (cur_m[i] == DMAX) ? 1'b1 : (pwm < cur_m[i]);
            busy_e[i] = (cur_m[i] != tgt_m[i]);
        end
        val_e = cur_m[idx];
        if (bnd) begin
            if (!fade_en) begin
                for (int i = 0; i < NUM_CH; i++) cur_m[i] = tgt_m[i];
            end else if (fcnt == FADE_PER - 1) begin
                fcnt = 0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (cur_m[i] < tgt_m[i]) cur_m[i]++;
                    else if (cur_m[i] > tgt_m[i]) cur_m[i]--;
                end
            end else begin
                fcnt++;
            end
        end
        if (wr_en && int'(wr_ch) < NUM_CH) tgt_m[wr_ch] = int'(wr_duty);
        c++;
        @(posedge clk);
        #1;
        chk("led",   led,   led_e);
        chk("busy",  busy,  busy_e);
        chk("sel",   sel,   32'(1) << idx);
        chk("value", value, val_e);
    endtask

    task automatic write(input int ch, input int duty);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_duty = WIDTH'(duty);
        $display("write ch=%0d duty=%0d fade_en=%0d phase=%0d", ch, duty, fade_en, c % PERIOD);
        step();
        wr_en = 1'b0;
    endtask

    // Advance until just after the next boundary edge.
    task automatic run_to_boundary();
        do step(); while ((c % PERIOD) != 0);
    endtask

    // High cycles of one LED over a full PWM period.
    task automatic count_high(input int ch, output int hi);
        hi = 0;
        repeat (PERIOD) begin
            step();
            hi += int'(led[ch]);
        end
    endtask

    initial begin
        int hi;
        bit found;

        // Asynchronous reset with no clock edge in between.
        rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        #1 chk_reset_outputs("reset_async");
        @(posedge clk);
        @(posedge clk);
        #1 chk_reset_outputs("reset_held");
        rst = 1'b1;

        // Jump mode: ch1 duty 4.
        fade_en = 1'b0;
        write(1, 4);
        step();
        chk("busy1_pending", busy[1], 1);
        run_to_boundary();
        step();
        chk("busy1_done", busy[1], 0);
        count_high(1, hi);
        chk("led1_high_of_32", hi, 8);

        // Duty extremes on ch0.
        write(0, 0);
        run_to_boundary();
        count_high(0, hi);
        chk("led0_duty0", hi, 0);
        write(0, DMAX);
        run_to_boundary();
        count_high(0, hi);
        chk("led0_duty_full", hi, PERIOD);

        // Fade ch2 0 -> 3 -> 0.
        fade_en = 1'b1;
        write(2, 3);
        run_to_boundary();
        run_to_boundary();
        step();
        chk("busy2_mid_fade_up", busy[2], 1);
        run_to_boundary();
        step();
        chk("busy2_fade_up_done", busy[2], 0);
        run_to_boundary();
        write(2, 0);
        run_to_boundary();
        run_to_boundary();
        step();
        chk("busy2_mid_fade_down", busy[2], 1);
        run_to_boundary();
        step();
        chk("busy2_fade_down_done", busy[2], 0);

        // Scanner shows ch1's live duty while ch1 is selected.
        found = 1'b0;
        for (int n = 0; n < 4 * SCAN_DIV * NUM_CH && !found; n++) begin
            step();
            if (sel == 4'b0010) found = 1'b1;
        end
        chk("scan_sel_ch1_seen", found, 1);
        chk("scan_value_ch1", value, 4);

        // Write landing on the boundary cycle takes effect one period later.
        fade_en = 1'b0;
        while ((c % PERIOD) != PERIOD - 1) step();
        write(3, 9);
        step();
        chk("busy3_after_boundary_write", busy[3], 1);
        run_to_boundary();
        step();
        chk("busy3_applied", busy[3], 0);
        count_high(3, hi);
        chk("led3_duty9", hi, 18);

        // Back-to-back writes: last one wins.
        write(3, 2);
        write(3, 5);
        write(3, 7);
        run_to_boundary();
        count_high(3, hi);
        chk("led3_last_write_wins", hi, 14);

        // Randomised traffic against the model.
        repeat (400) begin
            if ($urandom_range(15) == 0) fade_en = ~fade_en;
            if ($urandom_range(3) == 0) write($urandom_range(NUM_CH - 1), $urandom_range(DMAX));
            else step();
        end

        // Reset mid-run discards everything.
        #2 rst = 1'b0;
        #1 chk_reset_outputs("reset_midrun");
        model_reset();
        @(posedge clk);
        #1 chk_reset_outputs("reset_midrun_held");
        rst = 1'b1;
        repeat (300) begin
            if ($urandom_range(15) == 0) fade_en = ~fade_en;
            if ($urandom_range(3) == 0) write($urandom_range(NUM_CH - 1), $urandom_range(DMAX));
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
